// File: rtl/edge_detect_multi.sv
// edge_detect_multi
// -----------------------------------------------------------------------------
// Multi-channel edge detector. Each channel:
//   - synchronises an asynchronous level input (SYNC_STAGES flops),
//   - follows it with a small Moore FSM,
//   - produces a one-cycle tick on the selected edge.
// Ticks are also latched into sticky pending flags that the consumer clears
// with a per-channel acknowledge.
//
// Optional feature (macro EDGE_DETECT_COUNT_EN):
//   Adds a saturating CNT_W-bit event counter per channel. When the macro is
//   not defined, count is tied to zero and cnt_clr is ignored. The port list is
//   the same in both builds.
//
// Parameters:
//   N           number of channels (1..32)
//   SYNC_STAGES synchroniser depth (0..3; 0 = level already synchronous)
//   CNT_W       event counter width (only used with EDGE_DETECT_COUNT_EN)
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   level[N]     per-channel input levels
//   mode[2N]     per-channel edge select at [2i+1:2i]:
//                00 off, 01 rising, 10 falling, 11 both
//   ack[N]       per-channel pending clear, level-sensitive
//   cnt_clr      clears all event counters
//   tick[N]      one-cycle event pulse per channel
//   pending[N]   sticky event flags
//   any_pending  OR of all pending flags
//   count[N*CNT_W] per-channel saturating event counts
// -----------------------------------------------------------------------------
module edge_detect_multi #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       level,
    input  logic [2*N-1:0]     mode,
    input  logic [N-1:0]       ack,
    input  logic               cnt_clr,
    output logic [N-1:0]       tick,
    output logic [N-1:0]       pending,
    output logic               any_pending,
    output logic [N*CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ZERO,
        ST_EDGE_R,
        ST_ONE,
        ST_EDGE_F
    } state_t;

    localparam logic [1:0] ARM_LOAD = 2'(SYNC_STAGES);

    logic [N-1:0]   s_level;
    logic [1:0]     arm_q, arm_d;
    logic [2*N-1:0] mode_q, mode_d;
    logic [N-1:0]   pending_q, pending_d;
    state_t         state_q [N];
    state_t         state_d [N];

    // Synchroniser chain. With zero stages the input is taken as already
    // synchronous and feeds the FSMs directly.
    if (SYNC_STAGES > 0) begin : g_sync
        logic [N-1:0] sync_q [SYNC_STAGES];
        logic [N-1:0] sync_d [SYNC_STAGES];

        always_comb begin
            sync_d[0] = level;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_d[j] = sync_q[j-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j < SYNC_STAGES; j++) begin
                    sync_q[j] <= '0;
                end
            end else begin
                sync_q <= sync_d;
            end
        end

        assign s_level = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
        assign s_level = level;
    end

    // The arm counter holds the FSMs in INIT until the synchroniser has been
    // refilled with real samples, so the first load reflects the true level
    // and a level already high at reset never looks like a rising edge.
    always_comb begin
        arm_d = arm_q;
        if (arm_q != 2'd0) begin
            arm_d = arm_q - 2'd1;
        end
    end

    always_comb begin
        mode_d = mode;
    end

    // Per-channel edge tracking. The FSM follows the level regardless of mode;
    // mode only gates the tick, so changing mode can never fabricate an edge.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_INIT: begin
                    if (arm_q == 2'd0) begin
                        state_d[i] = s_level[i] ? ST_ONE : ST_ZERO;
                    end
                end
                ST_ZERO:   state_d[i] = s_level[i] ? ST_EDGE_R : ST_ZERO;
                ST_EDGE_R: state_d[i] = s_level[i] ? ST_ONE    : ST_EDGE_F;
                ST_ONE:    state_d[i] = s_level[i] ? ST_ONE    : ST_EDGE_F;
                ST_EDGE_F: state_d[i] = s_level[i] ? ST_EDGE_R : ST_ZERO;
                default:   state_d[i] = ST_INIT;
            endcase
        end
    end

    // mode bit 2i enables rising ticks, bit 2i+1 enables falling ticks.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            tick[i] = ((state_q[i] == ST_EDGE_R) && mode_q[2*i])
                   || ((state_q[i] == ST_EDGE_F) && mode_q[2*i+1]);
        end
    end

    // A tick arriving together with an acknowledge keeps the flag set, so an
    // event that lands while the previous one is being serviced is not lost.
    always_comb begin
        pending_d = (pending_q & ~ack) | tick;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_q     <= ARM_LOAD;
            mode_q    <= '0;
            pending_q <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ST_INIT;
            end
        end else begin
            arm_q     <= arm_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    assign pending     = pending_q;
    assign any_pending = |pending_q;

`ifdef EDGE_DETECT_COUNT_EN
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    // Saturating counters; a clear takes priority over a same-cycle tick.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (tick[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            count[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign count          = '0;
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed testbench for edge_detect_multi (N=4, SYNC_STAGES=2, CNT_W=2).
// Inputs change 1 time unit after a rising edge; outputs are observed at the
// same point, well away from the next active edge.
module tb_edge_detect_multi;

    localparam int N     = 4;
    localparam int SYNC  = 2;
    localparam int CNT_W = 2;

`ifdef EDGE_DETECT_COUNT_EN
    localparam logic [N*CNT_W-1:0] EXP_COUNT_SAT = 8'h03;
`else
    localparam logic [N*CNT_W-1:0] EXP_COUNT_SAT = 8'h00;
`endif

    logic               clk;
    logic               reset;
    logic [N-1:0]       level;
    logic [2*N-1:0]     mode;
    logic [N-1:0]       ack;
    logic               cnt_clr;
    logic [N-1:0]       tick;
    logic [N-1:0]       pending;
    logic               any_pending;
    logic [N*CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;
    int tick_seen;

    edge_detect_multi #(
        .N           (N),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .level       (level),
        .mode        (mode),
        .ack         (ack),
        .cnt_clr     (cnt_clr),
        .tick        (tick),
        .pending     (pending),
        .any_pending (any_pending),
        .count       (count)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] lvl, input logic [2*N-1:0] md,
                                 input logic [N-1:0] ak, input logic clr);
        level   = lvl;
        mode    = md;
        ack     = ak;
        cnt_clr = clr;
    endtask

    // Advance past the next rising edge and settle 1 unit after it.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset with ch0 high, all modes "both" ----------------
        reset = 1'b1;
        applyStimulus(4'b0001, 8'hFF, 4'b0000, 1'b0);
        repeat (3) waitCycle();
        checkOutput("reset_tick", 32'(tick), 32'h0);
        checkOutput("reset_pending", 32'(pending), 32'h0);
        checkOutput("reset_any", 32'(any_pending), 32'h0);
        checkOutput("reset_count", 32'(count), 32'h0);

        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            waitCycle();
            checkOutput("arming_tick", 32'(tick), 32'h0);
        end
        checkOutput("arming_any", 32'(any_pending), 32'h0);

        // ---------------- ch1 rising-only, latency and ack ----------------
        // modes: ch3=11 ch2=10 ch1=01 ch0=11
        applyStimulus(4'b0001, 8'hE7, 4'b0000, 1'b0);
        repeat (2) waitCycle();
        checkOutput("modechg_tick", 32'(tick), 32'h0);
        applyStimulus(4'b0011, 8'hE7, 4'b0000, 1'b0);
        waitCycle();                       // edge k
        checkOutput("ch1_lat_k", 32'(tick), 32'h0);
        waitCycle();                       // edge k+1
        checkOutput("ch1_lat_k1", 32'(tick), 32'h0);
        waitCycle();                       // edge k+2
        checkOutput("ch1_rise_tick", 32'(tick), 32'h2);
        checkOutput("ch1_pend_before", 32'(pending), 32'h0);
        waitCycle();
        checkOutput("ch1_tick_width", 32'(tick), 32'h0);
        checkOutput("ch1_pend_set", 32'(pending), 32'h2);
        checkOutput("ch1_any_set", 32'(any_pending), 32'h1);
        applyStimulus(4'b0011, 8'hE7, 4'b0010, 1'b0);
        waitCycle();
        checkOutput("ch1_pend_ack", 32'(pending), 32'h0);
        applyStimulus(4'b0001, 8'hE7, 4'b0000, 1'b0);
        tick_seen = 0;
        for (int c = 0; c < 5; c++) begin
            waitCycle();
            if (tick != 4'b0000) tick_seen++;
        end
        checkOutput("ch1_fall_no_tick", 32'(tick_seen), 32'h0);
        checkOutput("ch1_fall_no_pend", 32'(pending), 32'h0);

        // ---------------- one-cycle pulse on ch2 (fall) and ch3 (both) ----------------
        applyStimulus(4'b1101, 8'hE7, 4'b0000, 1'b0);
        waitCycle();                       // edge k samples the high
        applyStimulus(4'b0001, 8'hE7, 4'b0000, 1'b0);
        waitCycle();
        checkOutput("pulse_k1", 32'(tick), 32'h0);
        waitCycle();
        checkOutput("pulse_ch3_rise", 32'(tick), 32'h8);
        waitCycle();
        checkOutput("pulse_falls", 32'(tick), 32'hC);
        checkOutput("pulse_pend_a", 32'(pending), 32'h8);
        waitCycle();
        checkOutput("pulse_done", 32'(tick), 32'h0);
        checkOutput("pulse_pend_b", 32'(pending), 32'hC);
        applyStimulus(4'b0001, 8'hE7, 4'b1000, 1'b0);
        waitCycle();
        checkOutput("pulse_ack3", 32'(pending), 32'h4);
        checkOutput("pulse_any_mid", 32'(any_pending), 32'h1);
        applyStimulus(4'b0001, 8'hE7, 4'b0100, 1'b0);
        waitCycle();
        checkOutput("pulse_ack2", 32'(pending), 32'h0);
        checkOutput("pulse_any_clr", 32'(any_pending), 32'h0);

        // ---------------- tick and ack together on ch0 ----------------
        applyStimulus(4'b0000, 8'hE7, 4'b0000, 1'b0);
        repeat (2) waitCycle();
        checkOutput("ch0_fall_pre", 32'(tick), 32'h0);
        waitCycle();
        checkOutput("ch0_fall_tick", 32'(tick), 32'h1);
        applyStimulus(4'b0000, 8'hE7, 4'b0001, 1'b0);
        waitCycle();
        checkOutput("ch0_set_wins", 32'(pending), 32'h1);
        waitCycle();
        checkOutput("ch0_ack_clear", 32'(pending), 32'h0);

        // ---------------- mode change 00 -> 11 with ch0 high ----------------
        applyStimulus(4'b0000, 8'hE4, 4'b0000, 1'b0);
        waitCycle();
        applyStimulus(4'b0001, 8'hE4, 4'b0000, 1'b0);
        tick_seen = 0;
        for (int c = 0; c < 5; c++) begin
            waitCycle();
            if (tick != 4'b0000) tick_seen++;
        end
        checkOutput("mode_off_masks", 32'(tick_seen), 32'h0);
        applyStimulus(4'b0001, 8'hE7, 4'b0000, 1'b0);
        tick_seen = 0;
        for (int c = 0; c < 3; c++) begin
            waitCycle();
            if (tick != 4'b0000) tick_seen++;
        end
        checkOutput("mode_on_no_tick", 32'(tick_seen), 32'h0);
        applyStimulus(4'b0000, 8'hE7, 4'b0000, 1'b0);
        repeat (2) waitCycle();
        checkOutput("mode_fall_pre", 32'(tick), 32'h0);
        waitCycle();
        checkOutput("mode_fall_tick", 32'(tick), 32'h1);

        // ---------------- counter: clear, five rising edges, saturation ----------------
        applyStimulus(4'b0000, 8'hE5, 4'b0000, 1'b1);
        waitCycle();
        applyStimulus(4'b0000, 8'hE5, 4'b0000, 1'b0);
        checkOutput("count_clr_a", 32'(count), 32'h0);
        tick_seen = 0;
        for (int e = 0; e < 5; e++) begin
            applyStimulus(4'b0001, 8'hE5, 4'b0000, 1'b0);
            repeat (2) begin
                waitCycle();
                if (tick[0]) tick_seen++;
            end
            applyStimulus(4'b0000, 8'hE5, 4'b0000, 1'b0);
            repeat (2) begin
                waitCycle();
                if (tick[0]) tick_seen++;
            end
        end
        repeat (4) begin
            waitCycle();
            if (tick[0]) tick_seen++;
        end
        checkOutput("five_rise_ticks", 32'(tick_seen), 32'd5);
        checkOutput("count_saturate", 32'(count), 32'(EXP_COUNT_SAT));
        applyStimulus(4'b0000, 8'hE5, 4'b0000, 1'b1);
        waitCycle();
        applyStimulus(4'b0000, 8'hE5, 4'b0000, 1'b0);
        checkOutput("count_clr_b", 32'(count), 32'h0);

        // ---------------- reset mid-operation drops pending ----------------
        checkOutput("pre_reset_pend", 32'(pending), 32'h1);
        reset = 1'b1;
        waitCycle();
        checkOutput("midreset_pend", 32'(pending), 32'h0);
        checkOutput("midreset_any", 32'(any_pending), 32'h0);
        reset = 1'b0;
        repeat (2) waitCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_detect_multi.md
# edge_detect_multi

Parametrised multi-channel edge detector: the successor to the single-channel rising-edge Mealy/Moore detectors. Each of N channels synchronises an asynchronous level input, tracks it with a Moore FSM, and emits a one-cycle tick on a per-channel selectable edge (rising, falling, both, off). Ticks are also latched into sticky pending flags with per-channel acknowledge, so downstream FSMs or a register interface can service events without catching single-cycle pulses. Sits between raw button/sensor/status inputs and the control FSMs that consume their events.

## Interface
- N, 4: number of channels (1..32)
- SYNC_STAGES, 2: synchroniser flops per channel (0..3; 0 = level already synchronous)
- CNT_W, 8: event counter width per channel (used only with EDGE_DETECT_COUNT_EN)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- level  in  N  per-channel input levels (asynchronous when SYNC_STAGES > 0)
- mode  in  2N  per-channel edge select, channel i at [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- ack  in  N  per-channel pending clear, level-sensitive, sampled each clk
- cnt_clr  in  1  clears all event counters
- tick  out  N  one-cycle event pulse per channel (Moore, registered)
- pending  out  N  sticky event flags
- any_pending  out  1  OR-reduction of pending
- count  out  N*CNT_W  per-channel saturating event counts, channel i at [CNT_W*(i+1)-1:CNT_W*i]

## Operation
- Reset: sync flops, pending, counters cleared; all FSMs enter INIT; arm counter loaded with SYNC_STAGES. tick, pending, any_pending, count all 0.
- Arming: arm counter decrements once per cycle after reset deasserts; while nonzero, every FSM stays in INIT. With arm counter zero, INIT loads ONE if synchronised level = 1, else ZERO; no tick for this load. No spurious edge from a level already high at reset.
- Per-channel FSM states: INIT, ZERO, EDGE_R, ONE, EDGE_F. With s = synchronised level:
  - ZERO: s=1 -> EDGE_R, else ZERO
  - EDGE_R: s=0 -> EDGE_F, else ONE
  - ONE: s=0 -> EDGE_F, else ONE
  - EDGE_F: s=1 -> EDGE_R, else ZERO
- tick[i] = (state EDGE_R and mode[i] in {01,11}) or (state EDGE_F and mode[i] in {10,11}); mode decoded from the registered mode, updated each cycle.
- FSM always tracks level regardless of mode; mode 00 only masks tick. Mode change never creates a tick by itself.
- Level toggling every cycle (S=0): FSM alternates EDGE_R/EDGE_F; in mode 11 tick stays high continuously, one tick per edge.
- pending[i]: set on tick[i], cleared on ack[i]; simultaneous tick and ack -> stays 1 (set wins). ack on an idle channel has no effect.
- any_pending: combinational OR of pending registers.

## Timing
- Latency: level change first sampled on edge k -> tick high for the cycle following edge k+SYNC_STAGES (SYNC_STAGES+1 clocks; 1 clock at SYNC_STAGES=0).
- tick width: exactly one cycle per edge.
- pending rises one cycle after tick (on the edge that ends the tick cycle); falls on the edge following ack sampled high.
- Arming: first valid edge detection possible for levels changing after edge SYNC_STAGES+1 post-reset.
- Reset asserted mid-operation: on the next edge all outputs return to reset values and arming restarts; in-flight ticks are dropped.
- Pulses shorter than one clock period may be missed; not a requirement to capture them.

## Configuration
- EDGE_DETECT_COUNT_EN defined: per-channel CNT_W-bit counter increments on each tick, saturates at 2^CNT_W-1, cleared to 0 by cnt_clr (cnt_clr wins over a simultaneous tick); count updates one cycle after tick.
- Undefined: counters not built; count tied to 0; cnt_clr ignored. Port list identical in both builds.

## Test plan
- Reset with level=4'b0001 held high, mode=all 11 -> no tick during or after arming; ch0 FSM settles in ONE.
- ch1 mode=01, level[1] 0->1 sampled at edge k -> tick[1]=1 only in cycle after edge k+2; pending[1]=1 after; ack[1] pulse clears it next edge; falling edge later gives no tick.
- ch2 mode=10 and ch3 mode=11, 1-cycle high pulse on both (held >= 1 clock) -> ch2 one tick on fall, ch3 two ticks (rise then fall); any_pending=1 until both acked.
- tick[0] and ack[0] in the same cycle -> pending[0] remains 1; separate ack next cycle -> 0.
- Mode switched 00->11 while level[0] stable high -> no tick; next fall -> one tick.
- With EDGE_DETECT_COUNT_EN, CNT_W=2: five rising edges on ch0 mode=01 -> count ch0 = 3 (saturated); cnt_clr -> 0; without macro count stays 0.
